gpr_wb_scheduler: RTL and testbench
===================================

Name: gpr_wb_scheduler

Overview:
- Scoreboard plus write-port arbiter for the single-write-port GPR file (RV32E, 16 registers, x0 hardwired zero).
- Tracks registers with pending writes and stalls issue on RAW/WAW hazards.
- Shares the one GPR write port between the EXU and LSU writeback sources with round-robin arbitration.
- Drives the GPR write port from a registered stage; sits between IDU issue, EXU/LSU writeback and the GPR.

Parameters:
NR_REG, 16, number of architectural registers; valid indices are 0..NR_REG-1.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
iss_valid  in  1  IDU offers an instruction
iss_ready  out  1  instruction may issue (no hazard)
iss_rs1  in  5  source reg 1 (decoder drives 0 if unused)
iss_rs2  in  5  source reg 2 (decoder drives 0 if unused)
iss_rd  in  5  destination reg
iss_wen  in  1  instruction writes iss_rd
exu_valid  in  1  EXU writeback request
exu_ready  out  1  EXU request granted
exu_rd  in  5  EXU destination
exu_data  in  32  EXU result
lsu_valid  in  1  LSU writeback request
lsu_ready  out  1  LSU request granted
lsu_rd  in  5  LSU destination
lsu_data  in  32  LSU load data
gpr_wen  out  1  GPR write enable
gpr_waddr  out  5  GPR write address
gpr_wdata  out  32  GPR write data
busy_vec  out  NR_REG  scoreboard bits; bit 0 is always 0
err  out  1  sticky protocol-error flag

Behaviour:
- Reset is asynchronous. While reset is high: busy_vec=0, gpr_wen=0, gpr_waddr=0, gpr_wdata=0, err=0, and the round-robin pointer is 0 (EXU preferred). Outputs drop immediately on assertion. Any in-flight writeback is discarded.
- Scoreboard
  - busy(r) is 1 from the issue edge of a writer of r until the edge at which gpr_wen=1 with gpr_waddr=r.
  - x0 is never busy.
- Issue
  - iss_ready = !busy(iss_rs1) && !busy(iss_rs2) && !(iss_wen && busy(iss_rd)).
  - iss_ready is combinational and independent of iss_valid.
  - Issue fires on iss_valid && iss_ready. busy(iss_rd) is set at that edge if iss_wen=1 and iss_rd!=0.
- Arbitration
  - exu_ready = !(lsu_valid && ptr==1).
  - lsu_ready = !(exu_valid && ptr==0).
  - A lone requester is always granted.
  - On a grant, ptr flips to the non-granted unit. ptr is unchanged when neither unit is granted.
  - A requester holds valid/rd/data stable until ready.
- Write stage (latency 1)
  - At the edge of an accepted request with rd!=0: gpr_wen=1, gpr_waddr=rd, gpr_wdata=data for exactly one cycle.
  - With no accepted request, or rd==0: gpr_wen=0; waddr/wdata hold their previous values.
  - The write port never back-pressures.
- Busy clear
  - busy(gpr_waddr) clears at the edge ending the gpr_wen=1 cycle, the same edge on which the GPR captures the data.
  - From the next cycle, iss_ready and GPR reads both see the new value. No bypass exists.
- Simultaneous set and clear on one register is impossible: WAW blocks issue while busy. If it occurs anyway, set wins.
- Errors: err is set, sticky until reset, when any of these occurs:
  - an accepted writeback targets a non-busy, nonzero rd (the write is still performed);
  - any rd, rs1 or rs2 is ≥ NR_REG on a firing handshake (busy is not set and no write occurs for that rd).
- An EXU and LSU request to the same rd in the same cycle is arbitrated normally. The second write sets err, since the reg is no longer busy after the first write.

Test Plan:
- Reset mid-flight: issue rd=5, then assert reset for 1 cycle → busy_vec=0, gpr_wen=0 immediately; iss_ready=1 after release.
- RAW stall: issue rd=3 (iss_wen=1); next cycle offer rs1=3 → iss_ready=0. EXU writes x3=0xDEADBEEF → gpr_wen=1 one cycle after grant, waddr=3. iss_ready=1 the cycle after gpr_wen.
- Round-robin: rd=4 and rd=6 busy; exu_valid and lsu_valid both held high from reset → EXU granted first (x4), LSU second (x6). gpr_wen is high in two consecutive cycles with waddr 4 then 6.
- WAW stall: issue rd=7; offer rd=7 with rs1=rs2=0 → iss_ready=0 until x7 is written.
- x0 handling: issue rd=0, iss_wen=1 → busy_vec stays 0. EXU writeback rd=0 → exu_ready=1, gpr_wen stays 0, err=0.
- Errors: LSU writeback rd=9 while x9 is not busy → write occurs and err=1, holding until reset. Issue rd=20 → err=1 and busy_vec unchanged.

Source files
------------

// File: rtl/gpr_wb_scheduler_if.sv
// Handshake and write-port bundle between the IDU, the EXU/LSU writeback
// sources, the GPR write port and the writeback scheduler.
// The slave modport is the scheduler's view. The master modport is the view
// of the surrounding pipeline that drives issue and writeback requests.
interface gpr_wb_scheduler_if #(
    parameter int NR_REG = 16
);
    // issue side (IDU)
    logic              iss_valid;
    logic              iss_ready;
    logic [4:0]        iss_rs1;
    logic [4:0]        iss_rs2;
    logic [4:0]        iss_rd;
    logic              iss_wen;

    // EXU writeback request
    logic              exu_valid;
    logic              exu_ready;
    logic [4:0]        exu_rd;
    logic [31:0]       exu_data;

    // LSU writeback request
    logic              lsu_valid;
    logic              lsu_ready;
    logic [4:0]        lsu_rd;
    logic [31:0]       lsu_data;

    // GPR write port and status
    logic              gpr_wen;
    logic [4:0]        gpr_waddr;
    logic [31:0]       gpr_wdata;
    logic [NR_REG-1:0] busy_vec;
    logic              err;

    modport slave (
        input  iss_valid, iss_rs1, iss_rs2, iss_rd, iss_wen,
        input  exu_valid, exu_rd, exu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        output iss_ready, exu_ready, lsu_ready,
        output gpr_wen, gpr_waddr, gpr_wdata, busy_vec, err
    );

    modport master (
        output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_wen,
        output exu_valid, exu_rd, exu_data,
        output lsu_valid, lsu_rd, lsu_data,
        input  iss_ready, exu_ready, lsu_ready,
        input  gpr_wen, gpr_waddr, gpr_wdata, busy_vec, err
    );
endinterface

// File: rtl/gpr_wb_scheduler.sv
// Scoreboard and write-port arbiter for the single-write-port GPR file.
// Tracks registers with a pending write, stalls issue on RAW/WAW hazards,
// and shares the one GPR write port between EXU and LSU round-robin.
//
// Arbiter preference state:
//   state    | meaning
//   PREF_EXU | EXU wins when both units request (reset state)
//   PREF_LSU | LSU wins when both units request
//
// A register being written by the write stage is already "retired" for
// error checking purposes: a second writeback to it in that cycle is
// reported, even though busy_vec still shows it until the GPR captures.
module gpr_wb_scheduler #(
    parameter int NR_REG = 16
) (
    input logic              clock,
    input logic              reset,
    gpr_wb_scheduler_if.slave bus
);

    typedef enum logic {
        PREF_EXU = 1'b0,
        PREF_LSU = 1'b1
    } pref_t;

    pref_t             pref_q;
    logic [NR_REG-1:0] busy_q;
    logic [NR_REG-1:0] busy_nxt;
    logic              wen_q;
    logic [4:0]        waddr_q;
    logic [31:0]       wdata_q;
    logic              err_q;

    // busy/pending views widened to the full 5-bit index space
    logic [31:0]       busy_ext;
    logic [31:0]       pend_ext;

    logic              iss_ready;
    logic              iss_fire;
    logic              iss_bad;
    logic              set_en;
    logic              exu_ready;
    logic              lsu_ready;
    logic              exu_fire;
    logic              lsu_fire;
    logic              wb_fire;
    logic [4:0]        wb_rd;
    logic [31:0]       wb_data;
    logic              wb_rd_ok;
    logic              wb_write;
    logic              wb_err;

    function automatic logic reg_ok(input logic [4:0] r);
        return int'(r) < NR_REG;
    endfunction

    // Expose scoreboard to 5-bit indexing; indices past NR_REG read as idle.
    always_comb begin
        busy_ext = '0;
        for (int i = 0; i < NR_REG; i++) begin
            busy_ext[i] = busy_q[i];
        end
        pend_ext = busy_ext;
        if (wen_q) begin
            pend_ext[waddr_q] = 1'b0;
        end
    end

    // Issue hazard check and writeback arbitration.
    always_comb begin
        iss_ready = !busy_ext[bus.iss_rs1] && !busy_ext[bus.iss_rs2]
                    && !(bus.iss_wen && busy_ext[bus.iss_rd]);
        iss_fire  = bus.iss_valid && iss_ready;
        iss_bad   = iss_fire && (!reg_ok(bus.iss_rs1) || !reg_ok(bus.iss_rs2)
                                 || !reg_ok(bus.iss_rd));
        set_en    = iss_fire && bus.iss_wen && (bus.iss_rd != 5'd0)
                    && reg_ok(bus.iss_rd);

        exu_ready = !(bus.lsu_valid && (pref_q == PREF_LSU));
        lsu_ready = !(bus.exu_valid && (pref_q == PREF_EXU));
        exu_fire  = bus.exu_valid && exu_ready;
        lsu_fire  = bus.lsu_valid && lsu_ready;
        wb_fire   = exu_fire || lsu_fire;
        wb_rd     = exu_fire ? bus.exu_rd   : bus.lsu_rd;
        wb_data   = exu_fire ? bus.exu_data : bus.lsu_data;
        wb_rd_ok  = reg_ok(wb_rd);
        wb_write  = wb_fire && wb_rd_ok && (wb_rd != 5'd0);
        wb_err    = wb_fire && (!wb_rd_ok
                                || ((wb_rd != 5'd0) && !pend_ext[wb_rd]));
    end

    // Next scoreboard: clear the register the GPR captures now; issue set wins.
    always_comb begin
        busy_nxt = busy_q;
        for (int i = 0; i < NR_REG; i++) begin
            if (wen_q && (int'(waddr_q) == i)) begin
                busy_nxt[i] = 1'b0;
            end
            if (set_en && (int'(bus.iss_rd) == i)) begin
                busy_nxt[i] = 1'b1;
            end
        end
        busy_nxt[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_nxt;
        end
    end

    // Round-robin preference: after a grant the other unit is preferred.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pref_q <= PREF_EXU;
        end else begin
            case (pref_q)
                PREF_EXU: if (exu_fire) pref_q <= PREF_LSU;
                PREF_LSU: if (lsu_fire) pref_q <= PREF_EXU;
                default:  pref_q <= PREF_EXU;
            endcase
        end
    end

    // Registered GPR write stage; address/data hold when idle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            wen_q <= wb_write;
            if (wb_write) begin
                waddr_q <= wb_rd;
                wdata_q <= wb_data;
            end
        end
    end

    // Sticky protocol-error flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (iss_bad || wb_err) begin
            err_q <= 1'b1;
        end
    end

    assign bus.iss_ready = iss_ready;
    assign bus.exu_ready = exu_ready;
    assign bus.lsu_ready = lsu_ready;
    assign bus.gpr_wen   = wen_q;
    assign bus.gpr_waddr = waddr_q;
    assign bus.gpr_wdata = wdata_q;
    assign bus.busy_vec  = busy_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_gpr_wb_scheduler.sv
// Bench for gpr_wb_scheduler: directed scenarios with literal expectations,
// then randomized issue/writeback traffic, all cross-checked every cycle
// against a behavioural model of the scoreboard, arbiter and write stage.
module tb_gpr_wb_scheduler;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;

    gpr_wb_scheduler_if #(.NR_REG(16)) bus ();

    gpr_wb_scheduler #(.NR_REG(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // ---------------- behavioural model ----------------
    bit          m_busy [16];   // visible scoreboard
    bit          m_owed [16];   // issued writers not yet granted a writeback
    bit          m_pref_lsu;    // 1: LSU wins a tie
    bit          m_wen;
    int          m_waddr;
    logic [31:0] m_wdata;
    bit          m_err;

    function automatic bit mb(input int r);
        return (r < 16) ? m_busy[r] : 1'b0;
    endfunction

    function automatic bit exp_iss_ready();
        return !mb(int'(bus.iss_rs1)) && !mb(int'(bus.iss_rs2))
               && !(bus.iss_wen && mb(int'(bus.iss_rd)));
    endfunction

    function automatic bit exp_exu_ready();
        return !(bus.lsu_valid && m_pref_lsu);
    endfunction

    function automatic bit exp_lsu_ready();
        return !(bus.exu_valid && !m_pref_lsu);
    endfunction

    function automatic logic [15:0] mvec();
        logic [15:0] v;
        for (int i = 0; i < 16; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_busy[i] = 0;
            m_owed[i] = 0;
        end
        m_pref_lsu = 0;
        m_wen      = 0;
        m_waddr    = 0;
        m_wdata    = '0;
        m_err      = 0;
    endtask

    task automatic model_step();
        bit          eg, lg, ifire;
        int          wr, r1, r2, rd;
        logic [31:0] wd;
        eg    = bus.exu_valid && exp_exu_ready();
        lg    = bus.lsu_valid && exp_lsu_ready();
        ifire = bus.iss_valid && exp_iss_ready();
        r1 = int'(bus.iss_rs1);
        r2 = int'(bus.iss_rs2);
        rd = int'(bus.iss_rd);
        // GPR captures the staged write; its register stops being busy
        if (m_wen) m_busy[m_waddr] = 0;
        m_wen = 0;
        if (eg || lg) begin
            wr = eg ? int'(bus.exu_rd) : int'(bus.lsu_rd);
            wd = eg ? bus.exu_data : bus.lsu_data;
            if (wr >= 16) m_err = 1;
            else if (wr != 0) begin
                if (!m_owed[wr]) m_err = 1;
                m_owed[wr] = 0;
                m_wen   = 1;
                m_waddr = wr;
                m_wdata = wd;
            end
            m_pref_lsu = eg;
        end
        if (ifire) begin
            if (r1 >= 16 || r2 >= 16 || rd >= 16) m_err = 1;
            if (bus.iss_wen && rd != 0 && rd < 16) begin
                m_busy[rd] = 1;
                m_owed[rd] = 1;
            end
        end
    endtask

    initial forever begin
        @(posedge clock or posedge reset);
        if (reset) model_reset();
        else model_step();
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    initial forever begin
        @(negedge clock);
        if (!reset) begin
            check("m_iss_ready", 32'(bus.iss_ready), 32'(exp_iss_ready()));
            check("m_exu_ready", 32'(bus.exu_ready), 32'(exp_exu_ready()));
            check("m_lsu_ready", 32'(bus.lsu_ready), 32'(exp_lsu_ready()));
            check("m_gpr_wen",   32'(bus.gpr_wen),   32'(m_wen));
            check("m_gpr_waddr", 32'(bus.gpr_waddr), 32'(m_waddr));
            check("m_gpr_wdata", bus.gpr_wdata,      m_wdata);
            check("m_busy_vec",  32'(bus.busy_vec),  32'(mvec()));
            check("m_err",       32'(bus.err),       32'(m_err));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic smp();
        @(negedge clock);
    endtask

    task automatic clr_inputs();
        bus.iss_valid = 0; bus.iss_rs1 = 0; bus.iss_rs2 = 0; bus.iss_rd = 0; bus.iss_wen = 0;
        bus.exu_valid = 0; bus.exu_rd = 0; bus.exu_data = '0;
        bus.lsu_valid = 0; bus.lsu_rd = 0; bus.lsu_data = '0;
    endtask

    task automatic do_reset();
        reset = 1;
        clr_inputs();
        tick();
        tick();
        reset = 0;
    endtask

    task automatic offer(input bit v, input logic [4:0] rd, input bit wen,
                         input logic [4:0] rs1, input logic [4:0] rs2);
        bus.iss_valid = v; bus.iss_rd = rd; bus.iss_wen = wen;
        bus.iss_rs1 = rs1; bus.iss_rs2 = rs2;
    endtask

    task automatic pick(inout logic [15:0] pend, output logic [4:0] r);
        int list[$];
        int k;
        for (int i = 1; i < 16; i++) if (pend[i]) list.push_back(i);
        r = 0;
        if (list.size() > 0 && $urandom_range(0, 7) != 0) begin
            k = list[$urandom_range(0, list.size() - 1)];
            r = 5'(k);
            pend[k] = 1'b0;
        end
    endtask

    task automatic random_phase(input int ncyc);
        logic [15:0] pend;
        logic [4:0]  r;
        bit          ef, lf, fi, iwen;
        int          ird;
        pend = '0;
        for (int c = 0; c < ncyc; c++) begin
            smp();
            ef   = bus.exu_valid && bus.exu_ready;
            lf   = bus.lsu_valid && bus.lsu_ready;
            fi   = bus.iss_valid && bus.iss_ready;
            ird  = int'(bus.iss_rd);
            iwen = bus.iss_wen;
            tick();
            if (fi && iwen && ird != 0) pend[ird] = 1'b1;
            if (ef) bus.exu_valid = 0;
            if (lf) bus.lsu_valid = 0;
            if (!bus.exu_valid && $urandom_range(0, 2) != 0) begin
                pick(pend, r);
                bus.exu_valid = 1; bus.exu_rd = r; bus.exu_data = $urandom;
            end
            if (!bus.lsu_valid && $urandom_range(0, 2) != 0) begin
                pick(pend, r);
                bus.lsu_valid = 1; bus.lsu_rd = r; bus.lsu_data = $urandom;
            end
            offer(bit'($urandom_range(0, 1)), 5'($urandom_range(0, 15)),
                  $urandom_range(0, 3) != 0, 5'($urandom_range(0, 15)),
                  5'($urandom_range(0, 15)));
        end
        tick();
        clr_inputs();
        repeat (3) tick();
    endtask

    // ---------------- directed scenarios then random traffic ----------------
    initial begin
        clr_inputs();
        repeat (3) tick();
        reset = 0;
        smp();
        check("rst_busy",  32'(bus.busy_vec),  32'h0);
        check("rst_err",   32'(bus.err),       32'h0);
        check("rst_wen",   32'(bus.gpr_wen),   32'h0);
        check("rst_waddr", 32'(bus.gpr_waddr), 32'h0);
        check("rst_ready", 32'(bus.iss_ready), 32'h1);

        // reset mid-flight: x5 busy with its write staged when reset hits
        tick(); offer(1, 5'd5, 1, 5'd0, 5'd0);
        tick(); offer(0, 5'd0, 0, 5'd0, 5'd0);
        bus.exu_valid = 1; bus.exu_rd = 5'd5; bus.exu_data = 32'h1234_5678;
        smp();  check("mf_busy", 32'(bus.busy_vec), 32'h0020);
        tick(); bus.exu_valid = 0;
        smp();  check("mf_wen_staged", 32'(bus.gpr_wen), 32'h1);
        reset = 1;
        #1;
        check("mf_async_busy", 32'(bus.busy_vec), 32'h0);
        check("mf_async_wen",  32'(bus.gpr_wen),  32'h0);
        tick(); reset = 0; offer(0, 5'd5, 1, 5'd0, 5'd0);
        smp();  check("mf_ready_after", 32'(bus.iss_ready), 32'h1);

        // RAW stall on x3
        tick(); offer(1, 5'd3, 1, 5'd0, 5'd0);
        tick(); offer(1, 5'd0, 0, 5'd3, 5'd0);
        bus.exu_valid = 1; bus.exu_rd = 5'd3; bus.exu_data = 32'hDEAD_BEEF;
        smp();  check("raw_stall", 32'(bus.iss_ready), 32'h0);
        check("raw_exu_rdy", 32'(bus.exu_ready), 32'h1);
        tick(); bus.exu_valid = 0;
        smp();  check("raw_wen",   32'(bus.gpr_wen),   32'h1);
        check("raw_waddr", 32'(bus.gpr_waddr), 32'h3);
        check("raw_wdata", bus.gpr_wdata,      32'hDEAD_BEEF);
        check("raw_still_stall", 32'(bus.iss_ready), 32'h0);
        tick();
        smp();  check("raw_release", 32'(bus.iss_ready), 32'h1);
        check("raw_busy_clr", 32'(bus.busy_vec), 32'h0);

        // WAW stall on x7
        tick(); offer(1, 5'd7, 1, 5'd0, 5'd0);
        tick(); bus.lsu_valid = 1; bus.lsu_rd = 5'd7; bus.lsu_data = 32'hA5A5_0007;
        smp();  check("waw_stall", 32'(bus.iss_ready), 32'h0);
        tick(); bus.lsu_valid = 0;
        smp();  check("waw_wen",   32'(bus.gpr_wen),   32'h1);
        check("waw_waddr", 32'(bus.gpr_waddr), 32'h7);
        check("waw_stall2", 32'(bus.iss_ready), 32'h0);
        tick();
        smp();  check("waw_release", 32'(bus.iss_ready), 32'h1);
        tick(); offer(0, 5'd0, 0, 5'd0, 5'd0);
        bus.exu_valid = 1; bus.exu_rd = 5'd7; bus.exu_data = 32'h0000_0777;
        tick(); bus.exu_valid = 0;
        tick();

        // x0 is never busy and never written
        tick(); offer(1, 5'd0, 1, 5'd0, 5'd0);
        smp();  check("x0_iss_ready", 32'(bus.iss_ready), 32'h1);
        tick(); offer(0, 5'd0, 0, 5'd0, 5'd0);
        bus.exu_valid = 1; bus.exu_rd = 5'd0; bus.exu_data = 32'hFFFF_FFFF;
        smp();  check("x0_busy", 32'(bus.busy_vec), 32'h0);
        check("x0_exu_rdy", 32'(bus.exu_ready), 32'h1);
        tick(); bus.exu_valid = 0;
        smp();  check("x0_no_wen", 32'(bus.gpr_wen), 32'h0);
        check("x0_no_err", 32'(bus.err), 32'h0);

        // round-robin from reset: EXU first, then LSU, then EXU again
        do_reset();
        offer(1, 5'd4, 1, 5'd0, 5'd0);
        tick(); offer(1, 5'd6, 1, 5'd0, 5'd0);
        tick(); offer(0, 5'd0, 0, 5'd0, 5'd0);
        bus.exu_valid = 1; bus.exu_rd = 5'd4; bus.exu_data = 32'h0000_4444;
        bus.lsu_valid = 1; bus.lsu_rd = 5'd6; bus.lsu_data = 32'h0000_6666;
        smp();  check("rr_busy", 32'(bus.busy_vec), 32'h0050);
        check("rr_exu_first", 32'(bus.exu_ready), 32'h1);
        check("rr_lsu_wait",  32'(bus.lsu_ready), 32'h0);
        tick(); bus.exu_rd = 5'd0; bus.exu_data = 32'h0;
        smp();  check("rr_wen1",   32'(bus.gpr_wen),   32'h1);
        check("rr_waddr1", 32'(bus.gpr_waddr), 32'h4);
        check("rr_wdata1", bus.gpr_wdata,      32'h0000_4444);
        check("rr_exu_wait", 32'(bus.exu_ready), 32'h0);
        check("rr_lsu_turn", 32'(bus.lsu_ready), 32'h1);
        tick(); bus.lsu_valid = 0;
        smp();  check("rr_wen2",   32'(bus.gpr_wen),   32'h1);
        check("rr_waddr2", 32'(bus.gpr_waddr), 32'h6);
        check("rr_wdata2", bus.gpr_wdata,      32'h0000_6666);
        check("rr_exu_back", 32'(bus.exu_ready), 32'h1);
        tick(); bus.exu_valid = 0;
        smp();  check("rr_x0_no_wen", 32'(bus.gpr_wen), 32'h0);
        check("rr_busy_clr", 32'(bus.busy_vec), 32'h0);

        // writeback to a non-busy register: write happens, err sticks
        tick(); bus.lsu_valid = 1; bus.lsu_rd = 5'd9; bus.lsu_data = 32'h0000_0099;
        smp();  check("err_pre", 32'(bus.err), 32'h0);
        tick(); bus.lsu_valid = 0;
        smp();  check("err_wen",   32'(bus.gpr_wen),   32'h1);
        check("err_waddr", 32'(bus.gpr_waddr), 32'h9);
        check("err_set",   32'(bus.err),       32'h1);
        repeat (3) tick();
        smp();  check("err_sticky", 32'(bus.err), 32'h1);

        // out-of-range destination on issue
        do_reset();
        offer(1, 5'd20, 1, 5'd0, 5'd0);
        smp();  check("oor_ready", 32'(bus.iss_ready), 32'h1);
        tick(); offer(0, 5'd0, 0, 5'd0, 5'd0);
        smp();  check("oor_err",  32'(bus.err),      32'h1);
        check("oor_busy", 32'(bus.busy_vec), 32'h0);

        do_reset();
        random_phase(3000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
